command_decoder: RTL and testbench

COMMAND_DECODER -- requirements
Module: command_decoder

---
 rtl/command_decoder.sv | 140 ++++++++++++++
 tb/tb_command_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/command_decoder.sv
// rtl/command_decoder.sv - UART byte command decoder feeding BRAM A loads and READ_A issue
// Optional feature macro: RX_TIMEOUT_EN (abort a stalled load after TIMEOUT_CYCLES idle cycles)
module command_decoder #(
    parameter int MEM_DEPTH      = 1024,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       coprocessor_busy,
    output logic [1:0] command,
    output logic       ena_A,
    output logic       wea_A,
    output logic [9:0] addra_A,
    output logic [7:0] dina_A,
    output logic       loading,
    output logic       cmd_dropped
);

    typedef enum logic [1:0] {IDLE, LOAD_A, ISSUE} state_t;

    localparam logic [9:0] LAST_ADDR = 10'(MEM_DEPTH - 1);

    state_t     state_q;
    logic [9:0] cnt_q;
    logic [9:0] cnt_d;
    logic [1:0] command_q;
    logic       ena_q;
    logic       wea_q;
    logic [9:0] addra_q;
    logic [7:0] dina_q;
    logic       loading_q;
    logic       cmd_dropped_q;
    logic       pending_q;
    logic [7:0] pending_data_q;
    logic       byte_valid_d;
    logic [7:0] byte_d;

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q;
`endif

    // A byte caught during the one-cycle ISSUE state is replayed from IDLE next cycle.
    assign byte_valid_d = rx_ready | pending_q;
    assign byte_d       = pending_q ? pending_data_q : rx_data;
    assign cnt_d        = cnt_q + 10'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            command_q      <= 2'b00;
            ena_q          <= 1'b0;
            wea_q          <= 1'b0;
            addra_q        <= '0;
            dina_q         <= '0;
            loading_q      <= 1'b0;
            cmd_dropped_q  <= 1'b0;
            pending_q      <= 1'b0;
            pending_data_q <= '0;
`ifdef RX_TIMEOUT_EN
            timer_q        <= '0;
`endif
        end else begin
            command_q     <= 2'b00;
            ena_q         <= 1'b0;
            wea_q         <= 1'b0;
            cmd_dropped_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pending_q <= 1'b0;
                    if (byte_valid_d) begin
                        if (byte_d == 8'h01) begin
                            state_q   <= LOAD_A;
                            cnt_q     <= '0;
                            loading_q <= 1'b1;
`ifdef RX_TIMEOUT_EN
                            timer_q   <= '0;
`endif
                        end else if (byte_d == 8'h02) begin
                            if (coprocessor_busy) begin
                                cmd_dropped_q <= 1'b1;
                            end else begin
                                state_q   <= ISSUE;
                                command_q <= 2'b01;
                            end
                        end
                    end
                end
                ISSUE: begin
                    state_q <= IDLE;
                    if (rx_ready) begin
                        pending_q      <= 1'b1;
                        pending_data_q <= rx_data;
                    end
                end
                LOAD_A: begin
                    if (rx_ready) begin
                        ena_q   <= 1'b1;
                        wea_q   <= 1'b1;
                        dina_q  <= rx_data;
                        addra_q <= cnt_q;
`ifdef RX_TIMEOUT_EN
                        timer_q <= '0;
`endif
                        if (cnt_q == LAST_ADDR) begin
                            state_q   <= IDLE;
                            loading_q <= 1'b0;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
`ifdef RX_TIMEOUT_EN
                    else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q   <= IDLE;
                        loading_q <= 1'b0;
                        cnt_q     <= '0;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign command     = command_q;
    assign ena_A       = ena_q;
    assign wea_A       = wea_q;
    assign addra_A     = addra_q;
    assign dina_A      = dina_q;
    assign loading     = loading_q;
    assign cmd_dropped = cmd_dropped_q;

endmodule

// File: tb/tb_command_decoder.sv
// tb/tb_command_decoder.sv - scoreboard bench for command_decoder
module tb_command_decoder;

    localparam int K_CMD  = 1;
    localparam int K_DROP = 2;
    localparam int K_WR   = 3;

    typedef struct {
        int kind;
        int cyc;
        int addr;
        int data;
    } ev_t;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       coprocessor_busy;
    logic [1:0] command;
    logic       ena_A;
    logic       wea_A;
    logic [9:0] addra_A;
    logic [7:0] dina_A;
    logic       loading;
    logic       cmd_dropped;

    int  checks;
    int  errors;
    int  cyc;
    ev_t exp_q[$];

    command_decoder #(
        .MEM_DEPTH(1024),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .coprocessor_busy(coprocessor_busy),
        .command(command),
        .ena_A(ena_A),
        .wea_A(wea_A),
        .addra_A(addra_A),
        .dina_A(dina_A),
        .loading(loading),
        .cmd_dropped(cmd_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic push(input int kind, input int lat, input int addr, input int data);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc + lat;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input int kind, input int addr, input int data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual kind=%0d addr=%0d data=%0d cyc=%0d required none",
                     kind, addr, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.addr != addr || e.data != data) begin
                errors++;
                $display("FAIL event actual kind=%0d cyc=%0d addr=%0d data=%0d required kind=%0d cyc=%0d addr=%0d data=%0d",
                         kind, cyc, addr, data, e.kind, e.cyc, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (command != 2'b00) sb_check(K_CMD, 0, int'(command));
            if (cmd_dropped) sb_check(K_DROP, 0, 0);
            if (ena_A || wea_A) begin
                if (ena_A != wea_A) check("ena_wea_pair", int'(wea_A), int'(ena_A));
                sb_check(K_WR, int'(addra_A), int'(dina_A));
            end
        end
    end

    // Expected event (kind != 0) is observed lat cycles after the byte is sampled.
    task automatic send(input logic [7:0] b, input int gap, input int kind, input int lat,
                        input int addr, input int data);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        if (kind != 0) push(kind, lat, addr, data);
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b0;
        rx_data          = 8'h00;
        rx_ready         = 1'b0;
        coprocessor_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_command", int'(command), 0);
        check("reset_ena", int'(ena_A), 0);
        check("reset_wea", int'(wea_A), 0);
        check("reset_addr", int'(addra_A), 0);
        check("reset_data", int'(dina_A), 0);
        check("reset_loading", int'(loading), 0);
        check("reset_dropped", int'(cmd_dropped), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        send(8'h02, 4, K_CMD, 1, 0, 1);
        drain("read_a_idle");

        coprocessor_busy = 1'b1;
        send(8'h02, 4, K_DROP, 1, 0, 0);
        coprocessor_busy = 1'b0;
        drain("read_a_busy");

        send(8'h00, 3, 0, 0, 0, 0);
        send(8'hFF, 3, 0, 0, 0, 0);
        send(8'h03, 3, 0, 0, 0, 0);
        check("ignored_command", int'(command), 0);
        check("ignored_loading", int'(loading), 0);
        drain("ignored_bytes");

        // Second byte lands in the ISSUE cycle and must still be decoded.
        @(negedge clk);
        rx_data  = 8'h02;
        rx_ready = 1'b1;
        push(K_CMD, 1, 0, 1);
        @(negedge clk);
        push(K_CMD, 2, 0, 1);
        @(negedge clk);
        rx_ready = 1'b0;
        drain("back_to_back_issue");

        send(8'h01, 2, 0, 0, 0, 0);
        check("load_loading_on", int'(loading), 1);
        for (int i = 0; i < 1024; i++) begin
            send(8'(i), (i == 1023) ? 0 : 1, K_WR, 1, i, i % 256);
            if (i == 1022) check("load_loading_before_last", int'(loading), 1);
        end
        check("load_loading_last_strobe", int'(loading), 0);
        drain("full_load");
        send(8'h02, 4, K_CMD, 1, 0, 1);
        drain("read_after_load");

        send(8'h01, 2, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 2, K_WR, 1, i, 8'hA0 + i);
        check("abort_loading_before", int'(loading), 1);
        drain("abort_writes");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_command", int'(command), 0);
        check("abort_ena", int'(ena_A), 0);
        check("abort_wea", int'(wea_A), 0);
        check("abort_addr", int'(addra_A), 0);
        check("abort_data", int'(dina_A), 0);
        check("abort_loading", int'(loading), 0);
        check("abort_dropped", int'(cmd_dropped), 0);
        @(negedge clk);
        rst = 1'b1;
        send(8'h02, 4, K_CMD, 1, 0, 1);
        drain("read_after_abort");

`ifdef RX_TIMEOUT_EN
        send(8'h01, 2, 0, 0, 0, 0);
        send(8'h11, 2, K_WR, 1, 0, 8'h11);
        send(8'h22, 2, K_WR, 1, 1, 8'h22);
        send(8'h33, 0, K_WR, 1, 2, 8'h33);
        repeat (48) @(negedge clk);
        check("timeout_loading_idle49", int'(loading), 1);
        repeat (2) @(negedge clk);
        check("timeout_loading_idle51", int'(loading), 0);
        drain("timeout_writes");
        send(8'h02, 4, K_CMD, 1, 0, 1);
        drain("read_after_timeout");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
